// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID->EX pipeline stage with valid/ready, 2-entry skid buffer, flush and stall counter
module id_ex_pipe_stage #(
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 2,
  parameter int REG_AW  = 3,
  parameter int CTRL_W  = 24,
  parameter int STAT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [NUM_OPS*DATA_W-1:0] in_data,
  input  logic [3*REG_AW-1:0]       in_regs,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [CTRL_W-1:0]         in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_pc,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  output logic [3*REG_AW-1:0]       out_regs,
  output logic [DATA_W-1:0]         out_imm,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [STAT_W-1:0]         stall_cnt
);

  localparam int PW = 2*DATA_W + NUM_OPS*DATA_W + 3*REG_AW + CTRL_W;

  logic          m_v_q, m_v_d, s_v_q, s_v_d;
  logic [PW-1:0] m_pay_q, m_pay_d, s_pay_q, s_pay_d;
  logic          in_ready_q, in_ready_d;
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [PW-1:0] in_pay;
  logic [CTRL_W-1:0] m_ctrl;
  logic          accept, pop;

  assign in_pay = {in_pc, in_data, in_regs, in_imm, in_ctrl};
  assign accept = in_valid && in_ready_q;
  assign pop    = m_v_q && out_ready;

  // S only ever fills while M is stalled, so FIFO order is M then S
  always_comb begin
    m_v_d   = m_v_q;
    s_v_d   = s_v_q;
    m_pay_d = m_pay_q;
    s_pay_d = s_pay_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (pop) begin
      if (s_v_q) begin
        m_pay_d = s_pay_q;
        m_v_d   = 1'b1;
        s_v_d   = accept;
        if (accept) s_pay_d = in_pay;
      end else begin
        m_v_d = accept;
        if (accept) m_pay_d = in_pay;
      end
    end else if (!m_v_q) begin
      if (accept) begin
        m_v_d   = 1'b1;
        m_pay_d = in_pay;
      end
    end else if (accept) begin
      s_v_d   = 1'b1;
      s_pay_d = in_pay;
    end
    in_ready_d = !s_v_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (m_v_q && !out_ready && (stall_q != {STAT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_v_q      <= 1'b0;
      s_v_q      <= 1'b0;
      m_pay_q    <= '0;
      s_pay_q    <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      m_v_q      <= m_v_d;
      s_v_q      <= s_v_d;
      m_pay_q    <= m_pay_d;
      s_pay_q    <= s_pay_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign {out_pc, out_data, out_regs, out_imm, m_ctrl} = m_pay_q;
  // a bubble must never carry write enables downstream
  assign out_ctrl  = m_v_q ? m_ctrl : '0;
  assign out_valid = m_v_q;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_q;

endmodule
